// File: rtl/ram_16r_pkg.sv
// Shared types for the 16-read-port burst read front end.
// RD_BEAT_MASK_EN adds a per-lane valid mask to each buffered beat.
package ram_16r_pkg;

    localparam int NUM_RD_PORTS = 16;
    localparam int WORD_W       = 32;
    localparam int BEAT_W       = NUM_RD_PORTS * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [BEAT_W-1:0]       data;
        logic                    last;
`ifdef RD_BEAT_MASK_EN
        logic [NUM_RD_PORTS-1:0] mask;
`endif
    } beat_t;

endpackage

// File: rtl/ram_16r_beat_fifo.sv
// First-word-fall-through beat buffer; count feeds the read-issue credit check.
// Output is forced to zero while empty so the downstream bus idles at zero.
module ram_16r_beat_fifo
    import ram_16r_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  beat_t                        din_i,
    input  logic                         pop_i,
    output beat_t                        dout_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    beat_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_16r_burst_rd.sv
// Burst read front end for the 16R1W RAM: issues 16 addresses per beat under FIFO credit.
// Define RD_BEAT_MASK_EN to get the out_mask port and per-beat lane masks.
module ram_16r_burst_rd
    import ram_16r_pkg::*;
#(
    parameter int BLOCKSIZE  = 10,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [BLOCKSIZE:0]                   req_addr,
    input  logic [BLOCKSIZE+1:0]                 req_len,
    output logic [NUM_RD_PORTS*(BLOCKSIZE+1)-1:0] rd_addr,
    input  logic [NUM_RD_PORTS*WORD_W-1:0]       rd_dout,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [BEAT_W-1:0]                    out_data,
    output logic                                 out_last,
`ifdef RD_BEAT_MASK_EN
    output logic [NUM_RD_PORTS-1:0]              out_mask,
`endif
    output logic                                 busy
);
    localparam int AW = BLOCKSIZE + 1;
    localparam int LW = BLOCKSIZE + 2;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    state_e                    state_q, state_d;
    logic [AW-1:0]             base_q, base_d;
    logic [LW-1:0]             beats_q, beats_d;
    logic [LW-1:0]             len_c;
    logic [NUM_RD_PORTS*AW-1:0] rd_addr_q, addr_lanes;
    logic [RD_LAT-1:0]         pipe_vld_q, pipe_last_q;
    logic                      issue, is_last;
    int                        inflight;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_empty;
    beat_t                     fifo_din, fifo_dout;
`ifdef RD_BEAT_MASK_EN
    logic [NUM_RD_PORTS-1:0]             tail_mask_q, tail_mask_d;
    logic [RD_LAT-1:0][NUM_RD_PORTS-1:0] pipe_mask_q;
`endif

    assign len_c   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    assign is_last = (beats_q == LW'(1));

    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) inflight += int'(pipe_vld_q[i]);
    end

    // Credit: everything in the read pipe must already own a FIFO slot.
    assign issue = (state_q == ST_ISSUE) && (beats_q != '0) &&
                   ((inflight + int'(fifo_count)) < FIFO_DEPTH);

    always_comb begin
        addr_lanes = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) addr_lanes[i*AW +: AW] = base_q + AW'(i);
    end

    assign rd_addr = issue ? addr_lanes : rd_addr_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beats_d = beats_q;
`ifdef RD_BEAT_MASK_EN
        tail_mask_d = tail_mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ISSUE;
                    base_d  = req_addr;
                    beats_d = (len_c + LW'(NUM_RD_PORTS-1)) >> $clog2(NUM_RD_PORTS);
`ifdef RD_BEAT_MASK_EN
                    tail_mask_d = (len_c[3:0] == 4'd0) ? '1 :
                                  (NUM_RD_PORTS'(1) << len_c[3:0]) - NUM_RD_PORTS'(1);
`endif
                end
            end
            ST_ISSUE: begin
                if (beats_q == '0) begin
                    state_d = ST_IDLE;
                end else if (issue) begin
                    base_d  = base_q + AW'(NUM_RD_PORTS);
                    beats_d = beats_q - LW'(1);
                    if (is_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight == 0 && fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            beats_q     <= '0;
            rd_addr_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
`ifdef RD_BEAT_MASK_EN
            tail_mask_q <= '0;
            pipe_mask_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            beats_q        <= beats_d;
            rd_addr_q      <= rd_addr;
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue && is_last;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
`ifdef RD_BEAT_MASK_EN
            tail_mask_q    <= tail_mask_d;
            pipe_mask_q[0] <= is_last ? tail_mask_q : '1;
            for (int i = 1; i < RD_LAT; i++) pipe_mask_q[i] <= pipe_mask_q[i-1];
`endif
        end
    end

    always_comb begin
        fifo_din      = '0;
        fifo_din.data = rd_dout;
        fifo_din.last = pipe_last_q[RD_LAT-1];
`ifdef RD_BEAT_MASK_EN
        fifo_din.mask = pipe_mask_q[RD_LAT-1];
`endif
    end

    ram_16r_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pipe_vld_q[RD_LAT-1]),
        .din_i   (fifo_din),
        .pop_i   (out_valid && out_ready),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout.data;
    assign out_last  = fifo_dout.last;
`ifdef RD_BEAT_MASK_EN
    assign out_mask  = fifo_dout.mask;
`endif
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_16r_burst_rd.sv
// Scoreboard bench for ram_16r_burst_rd with a behavioural 2048-word, 1-cycle RAM.
module tb_ram_16r_burst_rd;
    import ram_16r_pkg::*;

    localparam int AW    = 11;
    localparam int DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       req_valid;
    logic                       req_ready;
    logic [AW-1:0]              req_addr;
    logic [AW:0]                req_len;
    logic [NUM_RD_PORTS*AW-1:0] rd_addr;
    logic [BEAT_W-1:0]          rd_dout = '0;
    logic                       out_valid;
    logic                       out_ready;
    logic [BEAT_W-1:0]          out_data;
    logic                       out_last;
    logic [15:0]                out_mask_w;
    logic                       busy;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              last;
        logic [15:0]       mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    ram_16r_burst_rd #(.BLOCKSIZE(10), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_addr   (rd_addr),
        .rd_dout   (rd_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef RD_BEAT_MASK_EN
        .out_mask  (out_mask_w),
`endif
        .busy      (busy)
    );
`ifndef RD_BEAT_MASK_EN
    assign out_mask_w = 16'hFFFF;
`endif

    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        return {8'hA5, 5'd0, a, ~a[7:0]};
    endfunction

    always @(posedge clk)
        for (int i = 0; i < NUM_RD_PORTS; i++)
            rd_dout[i*32 +: 32] <= memf(rd_addr[i*AW +: AW]);

    task automatic chk(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks hold-under-backpressure.
    logic              stall_prev = 1'b0;
    logic [BEAT_W-1:0] data_prev;
    logic              last_prev;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", BEAT_W'(out_valid), BEAT_W'(1));
                chk("hold_data", out_data, data_prev);
                chk("hold_last", BEAT_W'(out_last), BEAT_W'(last_prev));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", BEAT_W'(out_last), BEAT_W'(e.last));
`ifdef RD_BEAT_MASK_EN
                    chk("beat_mask", BEAT_W'(out_mask_w), BEAT_W'(e.mask));
`endif
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            last_prev  = out_last;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [AW-1:0] a, input int len);
        int   lc, nb, k;
        exp_t e;
        k = 0;
        while (!req_ready && k < 200) begin
            cyc();
            k++;
        end
        if (!req_ready) chk("req_ready_timeout", BEAT_W'(req_ready), BEAT_W'(1));
        lc = (len > 2048) ? 2048 : len;
        nb = (lc + 15) / 16;
        for (int b = 0; b < nb; b++) begin
            e = '0;
            for (int i = 0; i < 16; i++) e.data[i*32 +: 32] = memf(AW'(int'(a) + 16*b + i));
            e.last = (b == nb - 1);
            e.mask = (b == nb - 1 && (lc % 16) != 0) ? 16'((1 << (lc % 16)) - 1) : 16'hFFFF;
            exp_q.push_back(e);
        end
        req_addr  = a;
        req_len   = (AW+1)'(len);
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < max) begin
            cyc();
            k++;
        end
        chk(name, BEAT_W'(busy || exp_q.size() != 0), BEAT_W'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, BEAT_W'(req_ready), BEAT_W'(1));
        chk({tag, "_busy"}, BEAT_W'(busy), BEAT_W'(0));
        chk({tag, "_rd_addr"}, BEAT_W'(rd_addr), BEAT_W'(0));
        chk({tag, "_out_valid"}, BEAT_W'(out_valid), BEAT_W'(0));
        chk({tag, "_out_data"}, out_data, BEAT_W'(0));
        chk({tag, "_out_last"}, BEAT_W'(out_last), BEAT_W'(0));
`ifdef RD_BEAT_MASK_EN
        chk({tag, "_out_mask"}, BEAT_W'(out_mask_w), BEAT_W'(0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            issues;
        logic [AW-1:0] prev;

        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
        repeat (2) cyc();
        chk_reset_vals("rst0");
        rst = 1'b1;
        cyc();

        // Two-beat burst, timing checked cycle by cycle from the accept edge.
        send_req(11'h010, 32);
        chk("t1_c1_req_ready", BEAT_W'(req_ready), BEAT_W'(0));
        chk("t1_c1_busy", BEAT_W'(busy), BEAT_W'(1));
        chk("t1_c1_lane0", BEAT_W'(rd_addr[0 +: AW]), BEAT_W'(11'h010));
        chk("t1_c1_lane15", BEAT_W'(rd_addr[15*AW +: AW]), BEAT_W'(11'h01F));
        cyc();
        chk("t1_c2_out_valid", BEAT_W'(out_valid), BEAT_W'(0));
        chk("t1_c2_lane0", BEAT_W'(rd_addr[0 +: AW]), BEAT_W'(11'h020));
        cyc();
        chk("t1_c3_out_valid", BEAT_W'(out_valid), BEAT_W'(1));
        chk("t1_c3_out_last", BEAT_W'(out_last), BEAT_W'(0));
        chk("t1_c3_lane0_word", BEAT_W'(out_data[31:0]), BEAT_W'(32'hA500_10EF));
        cyc();
        chk("t1_c4_out_valid", BEAT_W'(out_valid), BEAT_W'(1));
        chk("t1_c4_out_last", BEAT_W'(out_last), BEAT_W'(1));
        chk("t1_c4_lane15_word", BEAT_W'(out_data[15*32 +: 32]), BEAT_W'(32'hA500_2FD0));
        cyc(); cyc();
        chk("t1_c6_busy", BEAT_W'(busy), BEAT_W'(0));
        chk("t1_c6_addr_hold", BEAT_W'(rd_addr[0 +: AW]), BEAT_W'(11'h020));

        // Wrap across the top of memory.
        send_req(11'h7F8, 16);
        chk("t2_c1_lane8", BEAT_W'(rd_addr[8*AW +: AW]), BEAT_W'(11'h000));
        wait_idle("t2_idle", 50);

        // Partial final beat.
        send_req(11'h123, 20);
        wait_idle("t3_idle", 50);

        // Backpressure: credit must stop issue once the buffer is committed.
        out_ready = 1'b0;
        prev = rd_addr[0 +: AW];
        send_req(11'h200, 128);
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_addr[0 +: AW] != prev) issues++;
            prev = rd_addr[0 +: AW];
            cyc();
        end
        chk("t4_issue_credit", BEAT_W'(issues <= DEPTH && issues > 0), BEAT_W'(1));
        chk("t4_stalled_valid", BEAT_W'(out_valid), BEAT_W'(1));
        out_ready = 1'b1;
        wait_idle("t4_idle", 400);

        // Zero-length request.
        send_req(11'h050, 0);
        chk("t5_c1_req_ready", BEAT_W'(req_ready), BEAT_W'(0));
        cyc();
        chk("t5_c2_req_ready", BEAT_W'(req_ready), BEAT_W'(1));
        chk("t5_c2_busy", BEAT_W'(busy), BEAT_W'(0));
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_valid", BEAT_W'(out_valid), BEAT_W'(0));
            cyc();
        end

        // Reset in the middle of a burst, then a clean burst.
        send_req(11'h100, 64);
        cyc(); cyc(); cyc();
        rst = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        exp_q.delete();
        cyc();
        rst = 1'b1;
        cyc();
        send_req(11'h300, 32);
        wait_idle("t6_idle", 50);

        chk("end_queue_empty", BEAT_W'(exp_q.size()), BEAT_W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
